// File: rtl/md_defs.sv
// Shared mult/div definitions: md_op encodings, FSM states and default latencies.
package md_defs;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: result computed at accept, committed after a fixed busy window.
module mult_div_unit
    import md_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  md_op,
    input  logic        cancel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        start,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               commit;
    md_op_e             op;
    logic               is_mul, is_div, accept;

    logic [31:0]        pend_hi, pend_lo;
    logic               pend_wr;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0]        res_hi, res_lo;

    always_comb begin
        op     = (md_op > 4'd8) ? MD_NONE : md_op_e'(md_op);
        is_mul = (op == MD_MULT) || (op == MD_MULTU);
        is_div = (op == MD_DIV) || (op == MD_DIVU);
        busy   = (state == ST_RUN);
        accept = ~busy & ~cancel;
        start  = (is_mul | is_div) & accept;
    end

    always_comb begin
        md_out = '0;
        if (op == MD_MFHI) md_out = hi;
        else if (op == MD_MFLO) md_out = lo;
    end

    always_comb begin
        prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};
        quot_s = $signed(rs_val) / $signed(rt_val);
        rem_s  = $signed(rs_val) % $signed(rt_val);
        res_hi = '0;
        res_lo = '0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                // most-negative / -1 overflows; define it as quotient = dividend, remainder 0
                if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
                    res_lo = rs_val;
                    res_hi = '0;
                end else begin
                    res_lo = quot_s;
                    res_hi = rem_s;
                end
            end
            MD_DIVU: begin
                res_lo = rs_val / rt_val;
                res_hi = rs_val % rt_val;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    cnt_next   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (start) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= ~(is_div && rt_val == 32'd0);
            end
            // commit only happens in RUN and accept only in IDLE, so they never collide
            if (commit && pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end else if (accept && op == MD_MTHI) begin
                hi <= rs_val;
            end else if (accept && op == MD_MTLO) begin
                lo <= rs_val;
            end
        end
    end

endmodule
